draw_manager: RTL and testbench

DRAW_MANAGER -- requirements
Module: draw_manager

---
 rtl/draw_manager_pkg.sv | 25 ++
 rtl/draw_addr_calc.sv | 26 ++
 rtl/draw_manager.sv | 143 ++++++++++++++
 tb/tb_draw_manager.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_manager_pkg.sv
// Shared draw definitions: framebuffer geometry, colour width, coordinate payload
// and the pass sequencer state encoding.
package draw_manager_pkg;

   localparam int unsigned DRAW_WIDTH  = 640;
   localparam int unsigned DRAW_HEIGHT = 480;
   localparam int unsigned COLOR_DEPTH = 9;
   localparam int unsigned FB_ADDR_W   = 19;
   localparam int unsigned COORD_W     = 32;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      WAIT_ACTIVE,
      DRAWING,
      NEXT,
      DONE
   } draw_state_e;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } coord_t;

endpackage

// File: rtl/draw_addr_calc.sv
// Signed range check of a pixel coordinate and its linear framebuffer address.
module draw_addr_calc #(
   parameter int unsigned DRAW_WIDTH  = draw_manager_pkg::DRAW_WIDTH,
   parameter int unsigned DRAW_HEIGHT = draw_manager_pkg::DRAW_HEIGHT
) (
   input  draw_manager_pkg::coord_t                    coord,
   output logic                                        valid_c,
   output logic [draw_manager_pkg::FB_ADDR_W-1:0]      addr_c
);

   localparam int unsigned AW  = draw_manager_pkg::FB_ADDR_W;
   localparam int          W_S = int'(DRAW_WIDTH);
   localparam int          H_S = int'(DRAW_HEIGHT);

   logic signed [31:0] x_s;
   logic signed [31:0] y_s;

   assign x_s = $signed(coord.x);
   assign y_s = $signed(coord.y);

   assign valid_c = (x_s >= 0) && (x_s < W_S) && (y_s >= 0) && (y_s < H_S);

   // Range is checked first, so the truncated product cannot wrap for accepted pixels.
   assign addr_c = (coord.y[AW-1:0] * AW'(DRAW_WIDTH)) + coord.x[AW-1:0];

endmodule

// File: rtl/draw_manager.sv
// Draw pass sequencer: grants the shared write bus to each source in ID order
// and forwards accepted pixels to the framebuffer one cycle after sampling.
module draw_manager #(
   parameter int unsigned NUM_SOURCES   = 2,
   parameter int unsigned COLOR_DEPTH   = draw_manager_pkg::COLOR_DEPTH,
   parameter int unsigned START_TIMEOUT = 1023,
   parameter int unsigned DRAW_WIDTH    = draw_manager_pkg::DRAW_WIDTH,
   parameter int unsigned DRAW_HEIGHT   = draw_manager_pkg::DRAW_HEIGHT,
   localparam int unsigned SEL_W        = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   frame,
   output logic [SEL_W-1:0]       write_source_sel,
   output logic                   write_awaited,
   input  logic                   write_active,
   input  logic [COLOR_DEPTH-1:0] write_color_data,
   input  logic                   write_transparent,
   input  logic [31:0]            write_x_addr,
   input  logic [31:0]            write_y_addr,
   output logic                   fb_we,
   output logic [18:0]            fb_addr,
   output logic [COLOR_DEPTH-1:0] fb_data,
   output logic                   pass_done,
   output logic                   overrun,
   output logic                   timeout_err
);

   import draw_manager_pkg::draw_state_e, draw_manager_pkg::coord_t;
   import draw_manager_pkg::IDLE, draw_manager_pkg::GRANT, draw_manager_pkg::WAIT_ACTIVE;
   import draw_manager_pkg::DRAWING, draw_manager_pkg::NEXT, draw_manager_pkg::DONE;

   localparam int unsigned CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

   draw_state_e      state_q, state_d;
   logic [SEL_W-1:0] sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             overrun_d, timeout_d;
   logic             pix_we_c;
   logic             valid_c;
   logic [18:0]      addr_c;
   coord_t           coord;

   assign coord = '{x: write_x_addr, y: write_y_addr};

   draw_addr_calc #(
      .DRAW_WIDTH  (DRAW_WIDTH),
      .DRAW_HEIGHT (DRAW_HEIGHT)
   ) u_addr_calc (
      .coord   (coord),
      .valid_c (valid_c),
      .addr_c  (addr_c)
   );

   assign pix_we_c = ((state_q == WAIT_ACTIVE) || (state_q == DRAWING)) &&
                     write_active && !write_transparent && valid_c;

   // Next-state and sticky flag logic.
   always_comb begin
      state_d   = state_q;
      sel_d     = write_source_sel;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      overrun_d = overrun;
      timeout_d = timeout_err;
      case (state_q)
         IDLE: begin
            sel_d = '0;
            if (frame || pend_q) begin
               state_d = GRANT;
               pend_d  = 1'b0;
            end
         end
         GRANT: begin
            cnt_d   = '0;
            state_d = WAIT_ACTIVE;
         end
         WAIT_ACTIVE: begin
            if (write_active) begin
               state_d = DRAWING;
            end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = NEXT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DRAWING: begin
            if (!write_active) state_d = NEXT;
         end
         NEXT: begin
            if (write_source_sel < SEL_W'(NUM_SOURCES - 1)) begin
               sel_d   = write_source_sel + SEL_W'(1);
               state_d = GRANT;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            sel_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A frame arriving as the pass completes is queued without counting as overrun.
      if (frame && (state_q != IDLE)) begin
         pend_d = 1'b1;
         if (state_q != DONE) overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q          <= IDLE;
         write_source_sel <= '0;
         cnt_q            <= '0;
         pend_q           <= 1'b0;
         overrun          <= 1'b0;
         timeout_err      <= 1'b0;
         write_awaited    <= 1'b0;
         pass_done        <= 1'b0;
         fb_we            <= 1'b0;
         fb_addr          <= '0;
         fb_data          <= '0;
      end else begin
         state_q          <= state_d;
         write_source_sel <= sel_d;
         cnt_q            <= cnt_d;
         pend_q           <= pend_d;
         overrun          <= overrun_d;
         timeout_err      <= timeout_d;
         write_awaited    <= (state_d == GRANT);
         pass_done        <= (state_d == DONE);
         fb_we            <= pix_we_c;
         if (pix_we_c) begin
            fb_addr <= addr_c;
            fb_data <= write_color_data;
         end
      end
   end

endmodule

// File: tb/tb_draw_manager.sv
// Self-checking bench for draw_manager: pixel vector table, randomized pixels
// against a coordinate model, and hand-written pass/timeout/overrun/reset sequences.
module tb_draw_manager;

   localparam int unsigned CD = 9;

   logic          clk = 1'b0;
   logic          resetN;
   logic          frame, frame1;
   logic          write_active, write_active1;
   logic [CD-1:0] write_color_data;
   logic          write_transparent;
   logic [31:0]   write_x_addr, write_y_addr;

   logic [0:0]    write_source_sel, write_source_sel1;
   logic          write_awaited, write_awaited1;
   logic          fb_we, fb_we1;
   logic [18:0]   fb_addr, fb_addr1;
   logic [CD-1:0] fb_data, fb_data1;
   logic          pass_done, pass_done1;
   logic          overrun, overrun1;
   logic          timeout_err, timeout_err1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   draw_manager dut (
      .clk(clk), .resetN(resetN), .frame(frame),
      .write_source_sel(write_source_sel), .write_awaited(write_awaited),
      .write_active(write_active), .write_color_data(write_color_data),
      .write_transparent(write_transparent),
      .write_x_addr(write_x_addr), .write_y_addr(write_y_addr),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .pass_done(pass_done), .overrun(overrun), .timeout_err(timeout_err)
   );

   draw_manager #(.NUM_SOURCES(1)) dut1 (
      .clk(clk), .resetN(resetN), .frame(frame1),
      .write_source_sel(write_source_sel1), .write_awaited(write_awaited1),
      .write_active(write_active1), .write_color_data(write_color_data),
      .write_transparent(write_transparent),
      .write_x_addr(write_x_addr), .write_y_addr(write_y_addr),
      .fb_we(fb_we1), .fb_addr(fb_addr1), .fb_data(fb_data1),
      .pass_done(pass_done1), .overrun(overrun1), .timeout_err(timeout_err1)
   );

   typedef struct {
      int            x;
      int            y;
      logic          t;
      logic [CD-1:0] c;
      logic          we;
      logic [18:0]   addr;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int x, input int y, input logic t, input logic [CD-1:0] c,
                               input logic we, input logic [18:0] addr);
      vec_t v;
      v.x = x; v.y = y; v.t = t; v.c = c; v.we = we; v.addr = addr;
      return v;
   endfunction

   // Reference: a pixel lands when opaque and inside the 640x480 raster, at row-major offset.
   function automatic vec_t model(input int x, input int y, input logic t, input logic [CD-1:0] c);
      vec_t v;
      v.x = x; v.y = y; v.t = t; v.c = c;
      v.we = !t && (x >= 0) && (x < 640) && (y >= 0) && (y < 480);
      v.addr = v.we ? 19'(y * 640 + x) : 19'd0;
      return v;
   endfunction

   task automatic drive_pix(input int x, input int y, input logic t, input logic [CD-1:0] c);
      write_x_addr      = 32'(x);
      write_y_addr      = 32'(y);
      write_transparent = t;
      write_color_data  = c;
   endtask

   task automatic wait_grant(input int exp_sel, output int cyc);
      cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (write_awaited) break;
         if (cyc > 40) begin
            chk("grant_timeout", 32'(cyc), 32'd0);
            break;
         end
      end
      chk("grant_sel", write_source_sel, exp_sel);
   endtask

   task automatic wait_done(input int bound, input logic pulse_frame, output int cyc);
      cyc = 0;
      while (1) begin
         @(negedge clk);
         frame = 1'b0;
         cyc++;
         if (pass_done) begin
            if (pulse_frame) frame = 1'b1;
            break;
         end
         if (cyc > bound) begin
            chk("done_timeout", 32'(cyc), 32'd0);
            break;
         end
      end
   endtask

   task automatic one_pixel();
      @(negedge clk);
      write_active = 1'b1;
      drive_pix(10, 10, 1'b0, 9'h0aa);
      @(negedge clk);
      write_active = 1'b0;
   endtask

   task automatic pulse_frame();
      @(negedge clk);
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
   endtask

   // Streams vecs on the bus from source 0 and checks each result one cycle later.
   task automatic stream_vecs(output int pulses, output int exp_pulses);
      pulses = 0;
      exp_pulses = 0;
      for (int i = 0; i <= vecs.size(); i++) begin
         @(negedge clk);
         if (i == 0) chk("awaited_one_cycle", write_awaited, 1'b0);
         if (i > 0) begin
            chk($sformatf("vec%0d_we", i - 1), fb_we, vecs[i - 1].we);
            if (fb_we) pulses++;
            if (vecs[i - 1].we) begin
               exp_pulses++;
               chk($sformatf("vec%0d_addr", i - 1), fb_addr, vecs[i - 1].addr);
               chk($sformatf("vec%0d_data", i - 1), fb_data, vecs[i - 1].c);
            end
         end
         if (i < vecs.size()) begin
            write_active = 1'b1;
            drive_pix(vecs[i].x, vecs[i].y, vecs[i].t, vecs[i].c);
         end else begin
            write_active = 1'b0;
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, pulses, exp_pulses, grants;

      resetN = 1'b0; frame = 1'b0; frame1 = 1'b0;
      write_active = 1'b0; write_active1 = 1'b0;
      drive_pix(0, 0, 1'b0, '0);
      repeat (3) @(negedge clk);
      chk("rst_sel", write_source_sel, 1'b0);
      chk("rst_awaited", write_awaited, 1'b0);
      chk("rst_fb_we", fb_we, 1'b0);
      chk("rst_fb_addr", fb_addr, 19'd0);
      chk("rst_fb_data", fb_data, '0);
      chk("rst_pass_done", pass_done, 1'b0);
      chk("rst_flags", {overrun, timeout_err}, 2'b00);
      resetN = 1'b1;
      repeat (2) @(negedge clk);

      // Single-source instance: pass_done two cycles after write_active falls.
      frame1 = 1'b1;
      @(negedge clk);
      frame1 = 1'b0;
      chk("s1_awaited", write_awaited1, 1'b1);
      chk("s1_sel", write_source_sel1, 1'b0);
      @(negedge clk);
      write_active1 = 1'b1;
      drive_pix(1, 2, 1'b0, 9'h155);
      @(negedge clk);
      chk("s1_fb_we", fb_we1, 1'b1);
      chk("s1_fb_addr", fb_addr1, 19'd1281);
      @(negedge clk);
      write_active1 = 1'b0;
      @(negedge clk);
      chk("s1_next_no_done", pass_done1, 1'b0);
      @(negedge clk);
      chk("s1_pass_done", pass_done1, 1'b1);
      chk("s1_done_sel", write_source_sel1, 1'b0);
      @(negedge clk);
      chk("s1_done_pulse", pass_done1, 1'b0);
      chk("s1_no_regrant", write_awaited1, 1'b0);

      // Vector table followed by 50 centre pixels and randomized pixels.
      vecs.push_back(mk(320, 240, 1'b0, 9'h1ff, 1'b1, 19'd153920));
      vecs.push_back(mk(-1, 0, 1'b0, 9'h001, 1'b0, 19'd0));
      vecs.push_back(mk(640, 0, 1'b0, 9'h002, 1'b0, 19'd0));
      vecs.push_back(mk(0, 480, 1'b0, 9'h003, 1'b0, 19'd0));
      vecs.push_back(mk(100, 100, 1'b1, 9'h004, 1'b0, 19'd0));
      vecs.push_back(mk(639, 479, 1'b0, 9'h0f5, 1'b1, 19'd307199));
      vecs.push_back(mk(0, 0, 1'b0, 9'h0a5, 1'b1, 19'd0));
      vecs.push_back(mk(639, 0, 1'b0, 9'h05a, 1'b1, 19'd639));
      vecs.push_back(mk(0, 479, 1'b0, 9'h123, 1'b1, 19'd306560));
      vecs.push_back(mk(-1, -1, 1'b0, 9'h007, 1'b0, 19'd0));
      vecs.push_back(mk(int'(32'h8000_0000), 5, 1'b0, 9'h008, 1'b0, 19'd0));
      vecs.push_back(mk(100, 1, 1'b0, 9'h0c3, 1'b1, 19'd740));
      for (int i = 0; i < 50; i++) vecs.push_back(mk(320, 240, 1'b0, 9'(i), 1'b1, 19'd153920));
      for (int i = 0; i < 40; i++)
         vecs.push_back(model(int'($urandom_range(0, 750)) - 50, int'($urandom_range(0, 580)) - 50,
                              ($urandom_range(0, 7) == 0), 9'($urandom)));

      pulse_frame();
      chk("a_awaited", write_awaited, 1'b1);
      chk("a_sel0", write_source_sel, 1'b0);
      stream_vecs(pulses, exp_pulses);
      chk("a_we_pulses", 32'(pulses), 32'(exp_pulses));
      @(negedge clk);
      chk("a_next_we", fb_we, 1'b0);
      chk("a_next_awaited", write_awaited, 1'b0);
      chk("a_next_sel", write_source_sel, 1'b0);
      @(negedge clk);
      chk("a_grant1", write_awaited, 1'b1);
      chk("a_sel1", write_source_sel, 1'b1);
      chk("a_no_timeout_yet", timeout_err, 1'b0);

      // Source 1 stays silent: 1023 wait cycles, then NEXT and DONE.
      wait_done(1100, 1'b0, cyc);
      chk("timeout_latency", 32'(cyc), 32'd1025);
      chk("timeout_err", timeout_err, 1'b1);
      chk("a_no_overrun", overrun, 1'b0);
      @(negedge clk);
      chk("a_done_pulse", pass_done, 1'b0);
      chk("a_done_sel", write_source_sel, 1'b0);

      // Frame during DRAWING: overrun, then an automatic pass after DONE.
      pulse_frame();
      chk("b_awaited", write_awaited, 1'b1);
      @(negedge clk);
      write_active = 1'b1;
      drive_pix(5, 5, 1'b0, 9'h011);
      @(negedge clk);
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
      chk("b_overrun", overrun, 1'b1);
      write_active = 1'b0;
      wait_grant(1, cyc);
      one_pixel();
      wait_done(20, 1'b0, cyc);
      wait_grant(0, cyc);
      chk("b_auto_restart", 32'(cyc), 32'd2);
      one_pixel();
      wait_grant(1, cyc);
      one_pixel();
      wait_done(20, 1'b0, cyc);
      grants = 0;
      repeat (10) begin
         @(negedge clk);
         if (write_awaited) grants++;
      end
      chk("b_pending_consumed", 32'(grants), 32'd0);
      chk("b_overrun_sticky", overrun, 1'b1);

      // Asynchronous reset while source 1 is drawing.
      pulse_frame();
      one_pixel();
      wait_grant(1, cyc);
      @(negedge clk);
      write_active = 1'b1;
      drive_pix(7, 3, 1'b0, 9'h0ee);
      @(negedge clk);
      chk("c_pre_rst_we", fb_we, 1'b1);
      #2 resetN = 1'b0;
      #1;
      chk("c_rst_outputs", {write_source_sel, write_awaited, fb_we, pass_done, overrun, timeout_err},
          6'd0);
      chk("c_rst_fb", {fb_addr, fb_data}, '0);
      @(negedge clk);
      write_active = 1'b0;
      resetN = 1'b1;
      grants = 0;
      repeat (20) begin
         @(negedge clk);
         if (write_awaited) grants++;
      end
      chk("c_no_grant_after_rst", 32'(grants), 32'd0);

      // Frame coinciding with DONE: queued pass, no overrun.
      pulse_frame();
      one_pixel();
      wait_grant(1, cyc);
      one_pixel();
      wait_done(20, 1'b1, cyc);
      wait_grant(0, cyc);
      frame = 1'b0;
      chk("d_queued_restart", 32'(cyc), 32'd2);
      chk("d_no_overrun", overrun, 1'b0);
      one_pixel();
      wait_grant(1, cyc);
      one_pixel();
      wait_done(20, 1'b0, cyc);
      chk("d_flags_clear", {overrun, timeout_err}, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
